cond_unit: RTL
==============

Name: cond_unit

Overview:
- Condition/flag stage of the ARM-style datapath. Sits directly downstream of the ALU and consumes its NZCV flag vector.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the current instruction against the stored flags.
- Gates the decoder's PC-write, register-write and memory-write requests, and the flag update itself, with the condition result.
- Counts condition-failed (squashed) instructions for performance monitoring.

Parameters:
- FLAGS_RST, 4'b0000, NZCV value loaded on reset.
- CNT_W, 16, width of the saturating squash counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  instruction-advance strobe; 0 = stage stalled, no state change
- Cond  in  4  instruction condition field (Instr[31:28])
- ALUFlags  in  4  {N,Z,C,V} from ALU, current instruction
- FlagW  in  2  flag-write request: [1] = N,Z group; [0] = C,V group
- PCS  in  1  decoder request to write PC (branch or Rd=R15)
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- NoWrite  in  1  compare-class op (CMP/CMN/TST/TEQ): suppress register write
- Flags  out  4  registered architectural {N,Z,C,V}
- CondEx  out  1  condition passed, combinational
- PCSrc  out  1  PCS & CondEx
- RegWrite  out  1  RegW & CondEx & ~NoWrite
- MemWrite  out  1  MemW & CondEx
- SquashCnt  out  CNT_W  count of instructions squashed by their condition

Behaviour:
- Reset: synchronous. On any rising clk with reset=1: Flags <= FLAGS_RST, SquashCnt <= 0. Reset takes precedence over en.
- Combinational outputs are not reset; they follow their inputs and the registered Flags.
- CondEx evaluates Cond against the registered Flags, never against ALUFlags:
  - 0000 EQ: Z; 0001 NE: ~Z
  - 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N
  - 0110 VS: V; 0111 VC: ~V
  - 1000 HI: C&~Z; 1001 LS: ~C|Z
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: reserved, CondEx=0 (instruction squashed)
- Flag update on rising clk when reset=0 and en=1:
  - FlagW[1] & CondEx: N,Z <= ALUFlags[3:2]
  - FlagW[0] & CondEx: C,V <= ALUFlags[1:0]
  - Each group updates independently; the other group holds.
- Latency: flags written by instruction i are visible to the CondEx of instruction i+1, one cycle later. No same-cycle bypass.
- en=0: Flags and SquashCnt hold. Combinational outputs still reflect the inputs; upstream must ignore them while stalled.
- Squash counter:
  - Increments on rising clk when reset=0, en=1 and CondEx=0.
  - Counts every squashed instruction, whatever its write requests.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Failed condition: no flag group updates, even with FlagW=2'b11.
- NoWrite affects only RegWrite. Flags and PCSrc are unaffected.
- Reset asserted mid-stream discards any pending flag update in that cycle.

Test Plan:
- Reset, then Cond=1110, FlagW=11, ALUFlags=0100, en=1 for one cycle -> Flags=0100. Next cycle, Cond=0000 -> CondEx=1.
- Flags=0100, Cond=0001, RegW=1, MemW=1, PCS=1 -> CondEx=0, RegWrite=MemWrite=PCSrc=0. After one enabled clock, SquashCnt=1 and Flags unchanged.
- Flags=0000, Cond=1110, FlagW=01, ALUFlags=1111 -> Flags=0011 after the clock; N,Z held. Then FlagW=10, ALUFlags=1000 -> Flags=1011.
- Sweep all 16 Cond values across all 16 Flags values, comparing CondEx against the table. Includes GE/LT with N=1,V=1 -> GE=1, and 1111 -> CondEx=0.
- en=0 with FlagW=11, Cond=1110, ALUFlags=1111 for 3 cycles -> Flags unchanged and SquashCnt unchanged. Raise en -> Flags=1111 one cycle later.
- CNT_W=2: five squashed enabled cycles -> SquashCnt=3 (saturated). Then reset=1 together with en=1 and FlagW=11 -> Flags=FLAGS_RST and SquashCnt=0.

Source files
------------

// File: rtl/cond_unit_if.sv
// Bus between the decode/ALU side and the condition stage: instruction
// controls and flags in, gated write enables, flags and squash count out.
interface cond_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic [3:0]       Flags;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [CNT_W-1:0] SquashCnt;

    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  Flags, CondEx, PCSrc, RegWrite, MemWrite, SquashCnt
    );

    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output Flags, CondEx, PCSrc, RegWrite, MemWrite, SquashCnt
    );
endinterface

// File: rtl/cond_unit.sv
// Condition/flag stage: holds NZCV, evaluates the instruction condition
// against the stored flags, gates write requests and counts squashed ops.
module cond_unit #(
    parameter logic [3:0]  FLAGS_RST = 4'b0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cond_ex;
    logic             n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition evaluated on registered flags only; no ALU bypass.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // N,Z and C,V groups update independently, only for passing instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
        end else if (bus.en && cond_ex) begin
            if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Saturating count of condition-failed instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.en && !cond_ex && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.Flags     = flags_q;
    assign bus.CondEx    = cond_ex;
    assign bus.PCSrc     = bus.PCS & cond_ex;
    assign bus.RegWrite  = bus.RegW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite  = bus.MemW & cond_ex;
    assign bus.SquashCnt = cnt_q;
endmodule
